// File: rtl/fmul64_rsh_round.sv
// FP64 multiplier underflow path: right-shift the product significand,
// extract kept/guard/sticky, round to a subnormal or minimum-normal fraction.
module fmul64_rsh_round (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [105:0] sig_i,
  input  logic [5:0]   rsh_num_i,
  input  logic         sign_i,
  input  logic [2:0]   rm_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [51:0]  frac_o,
  output logic         hidden_o,
  output logic         carry_o,
  output logic         inexact_o,
  output logic         uf_o
);

  logic        s1_valid;
  logic        s2_valid;
  logic        s1_en;
  logic        s2_en;

  logic [52:0] s1_k;
  logic        s1_g;
  logic        s1_s;
  logic        s1_sign;
  logic [2:0]  s1_rm;

  logic [53:0] win;
  logic [52:0] k_d;
  logic        g_d;
  logic [6:0]  lim;
  logic [105:0] thr;
  logic        s_d;

  logic        rtz;
  logic        rdn;
  logic        rup;
  logic        rmm;
  logic        inx;
  logic        inc;
  logic [53:0] r;
  logic        uf_d;

  assign s2_en   = ~s2_valid | ready_i;
  assign s1_en   = ~s1_valid | s2_en;
  assign ready_o = s1_en;
  assign valid_o = s2_valid;

  // Only product bits at or above 51 can reach K or G after a right shift.
  assign win = sig_i[104:51] >> rsh_num_i;
  assign k_d = win[53:1];
  assign g_d = win[0];

  // Sticky mask covers every source bit that lands below position 51.
  assign lim = {1'b0, rsh_num_i} + 7'd51;
  assign thr = ~({106{1'b1}} << lim);
  assign s_d = |(sig_i & thr);

  assign rtz = (s1_rm == 3'd1);
  assign rdn = (s1_rm == 3'd2);
  assign rup = (s1_rm == 3'd3);
  assign rmm = (s1_rm == 3'd4);
  assign inx = s1_g | s1_s;

  always_comb begin
    inc = s1_g & (s1_k[0] | s1_s);
    unique case (1'b1)
      rtz:     inc = 1'b0;
      rdn:     inc = s1_sign & inx;
      rup:     inc = ~s1_sign & inx;
      rmm:     inc = s1_g;
      default: inc = s1_g & (s1_k[0] | s1_s);
    endcase
  end

  assign r    = {1'b0, s1_k} + {53'd0, inc};
  assign uf_d = inx & ~r[52] & ~r[53];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_k      <= '0;
      s1_g      <= 1'b0;
      s1_s      <= 1'b0;
      s1_sign   <= 1'b0;
      s1_rm     <= '0;
      s2_valid  <= 1'b0;
      frac_o    <= '0;
      hidden_o  <= 1'b0;
      carry_o   <= 1'b0;
      inexact_o <= 1'b0;
      uf_o      <= 1'b0;
    end else begin
      if (s1_en) begin
        s1_valid <= valid_i;
      end
      if (s1_en & valid_i) begin
        s1_k    <= k_d;
        s1_g    <= g_d;
        s1_s    <= s_d;
        s1_sign <= sign_i;
        s1_rm   <= rm_i;
      end
      if (s2_en) begin
        s2_valid <= s1_valid;
      end
      if (s2_en & s1_valid) begin
        frac_o    <= r[51:0];
        hidden_o  <= r[52];
        carry_o   <= r[53];
        inexact_o <= inx;
        uf_o      <= uf_d;
      end
    end
  end

endmodule

// File: tb/tb_fmul64_rsh_round.sv
// Bench for fmul64_rsh_round: directed vectors, handshake corners,
// and randomized traffic against a bit-level reference model.
module tb_fmul64_rsh_round;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_i;
  logic         ready_o;
  logic [105:0] sig_i;
  logic [5:0]   rsh_num_i;
  logic         sign_i;
  logic [2:0]   rm_i;
  logic         valid_o;
  logic         ready_i;
  logic [51:0]  frac_o;
  logic         hidden_o;
  logic         carry_o;
  logic         inexact_o;
  logic         uf_o;

  fmul64_rsh_round dut (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .sig_i     (sig_i),
    .rsh_num_i (rsh_num_i),
    .sign_i    (sign_i),
    .rm_i      (rm_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .frac_o    (frac_o),
    .hidden_o  (hidden_o),
    .carry_o   (carry_o),
    .inexact_o (inexact_o),
    .uf_o      (uf_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [51:0] frac;
    logic        hid;
    logic        car;
    logic        inx;
    logic        uf;
  } res_t;

  typedef struct {
    logic [105:0] sig;
    logic [5:0]   rsh;
    logic         sign;
    logic [2:0]   rm;
    res_t         exp;
  } vec_t;

  vec_t vecs[$];
  res_t sb_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic void check(string name, logic [63:0] act,
                                logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic res_t cur_out();
    return {frac_o, hidden_o, carry_o, inexact_o, uf_o};
  endfunction

  // Reference: shift by definition, sticky by source-bit destination.
  function automatic res_t model(logic [105:0] sig, logic [5:0] rsh,
                                 logic sign, logic [2:0] rm);
    logic [105:0] x;
    logic [52:0]  k;
    logic         g;
    logic         s;
    logic         inc;
    logic [53:0]  r;
    res_t         o;
    x = sig >> rsh;
    k = x[104:52];
    g = x[51];
    s = 1'b0;
    for (int i = 0; i < 106; i++)
      if (sig[i] && (i - int'(rsh)) < 51) s = 1'b1;
    case (rm)
      3'd1:    inc = 1'b0;
      3'd2:    inc = sign & (g | s);
      3'd3:    inc = ~sign & (g | s);
      3'd4:    inc = g;
      default: inc = g & (k[0] | s);
    endcase
    r = {1'b0, k} + {53'd0, inc};
    o.frac = r[51:0];
    o.hid  = r[52];
    o.car  = r[53];
    o.inx  = g | s;
    o.uf   = (g | s) & ~r[52] & ~r[53];
    return o;
  endfunction

  task automatic add_vec(logic [105:0] sig, logic [5:0] rsh, logic sign,
                         logic [2:0] rm, logic [51:0] frac, logic hid,
                         logic car, logic inx, logic uf);
    vec_t v;
    v.sig  = sig;
    v.rsh  = rsh;
    v.sign = sign;
    v.rm   = rm;
    v.exp  = {frac, hid, car, inx, uf};
    vecs.push_back(v);
  endtask

  function automatic logic [105:0] rand_sig();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    case ($urandom % 4)
      0: r = r & ~((128'd1 << $urandom_range(0, 70)) - 128'd1);
      1: r = 128'd1 << $urandom_range(0, 104);
      default: ;
    endcase
    if ($urandom % 4 != 0) r[104] = 1'b1;
    return {1'b0, r[104:0]};
  endfunction

  function automatic logic [5:0] rand_rsh();
    if ($urandom % 3 == 0) return 6'($urandom_range(48, 63));
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic drive_rand();
    sig_i     = rand_sig();
    rsh_num_i = rand_rsh();
    sign_i    = 1'($urandom);
    rm_i      = 3'($urandom);
  endtask

  // Scoreboard and hold monitor, sampled mid-cycle.
  res_t last_out;
  logic stall_prev = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev)
          check("hold", {7'd0, valid_o, cur_out()}, {7'd0, 1'b1, last_out});
        if (valid_o && ready_i) begin
          if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb: unexpected output %h, none expected",
                     cur_out());
          end else begin
            check("sb", 64'(cur_out()), 64'(sb_q.pop_front()));
          end
        end
        if (valid_i && ready_o)
          sb_q.push_back(model(sig_i, rsh_num_i, sign_i, rm_i));
        stall_prev = valid_o && !ready_i;
        last_out   = cur_out();
      end
    end
  end

  task automatic send(logic [105:0] sig, logic [5:0] rsh, logic sign,
                      logic [2:0] rm);
    logic a;
    a = 1'b0;
    @(posedge clk);
    #1;
    sig_i     = sig;
    rsh_num_i = rsh;
    sign_i    = sign;
    rm_i      = rm;
    valid_i   = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      a = ready_o;
      @(posedge clk);
      #1;
      if (a) break;
    end
    if (!a) check("accept_timeout", 64'(a), 64'd1);
    valid_i = 1'b0;
  endtask

  task automatic wait_check(string name, res_t exp);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!valid_o && lat < 20);
    check({name, "_lat"}, 64'(lat), 64'd2);
    check(name, 64'(cur_out()), 64'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: timeout reached, test did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int nout;
    logic a;

    add_vec(106'd1 << 104, 6'd1, 1'b0, 3'd0, 52'd1 << 51, 0, 0, 0, 0);
    add_vec({1'b0, {105{1'b1}}}, 6'd0, 1'b0, 3'd0, 52'd0, 0, 1, 1, 0);
    add_vec(106'd1 << 104, 6'd60, 1'b0, 3'd3, 52'd1, 0, 0, 1, 1);
    add_vec(106'd1 << 104, 6'd60, 1'b0, 3'd2, 52'd0, 0, 0, 1, 1);
    add_vec(106'd1 << 104, 6'd60, 1'b0, 3'd1, 52'd0, 0, 0, 1, 1);
    add_vec(106'd1 << 104, 6'd60, 1'b1, 3'd2, 52'd1, 0, 0, 1, 1);
    add_vec((106'd1 << 104) | (106'd1 << 51), 6'd0, 1'b0, 3'd0,
            52'd0, 1, 0, 1, 0);
    add_vec((106'd1 << 104) | (106'd1 << 52) | (106'd1 << 51), 6'd0,
            1'b0, 3'd0, 52'd2, 1, 0, 1, 0);
    add_vec((106'd1 << 104) | (106'd1 << 51), 6'd0, 1'b0, 3'd4,
            52'd1, 1, 0, 1, 0);
    add_vec((106'd1 << 104) | (106'd1 << 52) | (106'd1 << 51), 6'd0,
            1'b0, 3'd7, 52'd2, 1, 0, 1, 0);
    add_vec(106'd1 << 104, 6'd53, 1'b0, 3'd0, 52'd0, 0, 0, 1, 1);
    add_vec(106'd1 << 104, 6'd53, 1'b0, 3'd4, 52'd1, 0, 0, 1, 1);
    add_vec(106'd1 << 104, 6'd54, 1'b0, 3'd0, 52'd0, 0, 0, 1, 1);
    add_vec(106'd1 << 104, 6'd54, 1'b0, 3'd3, 52'd1, 0, 0, 1, 1);
    add_vec(106'd1 << 104, 6'd63, 1'b0, 3'd4, 52'd0, 0, 0, 1, 1);

    rst       = 1'b1;
    valid_i   = 1'b0;
    ready_i   = 1'b1;
    sig_i     = '0;
    rsh_num_i = '0;
    sign_i    = 1'b0;
    rm_i      = '0;
    #1;
    check("reset_out", {7'd0, valid_o, cur_out()}, 64'd0);
    check("reset_ready", 64'(ready_o), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      send(vecs[i].sig, vecs[i].rsh, vecs[i].sign, vecs[i].rm);
      wait_check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Backpressure: four beats offered while the output is stalled.
    @(posedge clk);
    #1;
    ready_i = 1'b0;
    acc = 0;
    drive_rand();
    valid_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      a = valid_i & ready_o;
      @(posedge clk);
      #1;
      if (a) begin
        acc++;
        if (acc < 4) drive_rand();
        else valid_i = 1'b0;
      end
    end
    check("bp_accepts", 64'(acc), 64'd2);
    check("bp_ready_low", 64'(ready_o), 64'd0);
    ready_i = 1'b1;
    nout = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (valid_o) nout++;
      a = valid_i & ready_o;
      @(posedge clk);
      #1;
      if (a) begin
        acc++;
        if (acc < 4) drive_rand();
        else valid_i = 1'b0;
      end
    end
    check("bp_drain_nogap", 64'(nout), 64'd4);
    check("bp_total", 64'(acc), 64'd4);
    repeat (3) @(posedge clk);
    #1;
    check("bp_empty", 64'(sb_q.size()), 64'd0);

    // Reset with both stages full.
    ready_i = 1'b0;
    send(rand_sig(), rand_rsh(), 1'b0, 3'd0);
    send(rand_sig(), rand_rsh(), 1'b1, 3'd3);
    #2;
    check("pre_rst_valid", 64'(valid_o), 64'd1);
    rst = 1'b1;
    #1;
    sb_q.delete();
    check("rst_async_out", {7'd0, valid_o, cur_out()}, 64'd0);
    check("rst_async_ready", 64'(ready_o), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_i = 1'b1;
    send(vecs[7].sig, vecs[7].rsh, vecs[7].sign, vecs[7].rm);
    wait_check("post_rst", vecs[7].exp);

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      drive_rand();
      valid_i = ($urandom % 4) != 0;
      ready_i = ($urandom % 4) != 0;
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rand_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
